controle_linha_engarrafamento: RTL and testbench

- Upstream sequencer for the bottling/corking counter stage.
- Drives the conveyor, fill valve and corker for one bottle at a time.
- Emits one single-cycle pulse per cork consumed and one per sealed bottle. These pulses replace the debounced push-button events that currently feed the bottle counter (pulso_garrafa) and cork counter (pulso_rolha).
- Consumes the counter stage's "corks available" flag and holds the line when stock is empty.

---
 rtl/controle_linha_engarrafamento_pkg.sv | 21 ++
 rtl/controle_linha_engarrafamento_sincronizador_borda.sv | 28 ++
 rtl/controle_linha_engarrafamento.sv | 144 ++++++++++++++
 tb/tb_controle_linha_engarrafamento.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_linha_engarrafamento_pkg.sv
// Shared definitions for the bottling line sequencer: state codes shown on the
// display, default timing constants and the estado width.
package controle_linha_engarrafamento_pkg;

    localparam int ESTADO_W              = 3;
    localparam int T_ENCHE_PADRAO        = 8;
    localparam int T_VEDA_PADRAO         = 4;
    localparam int T_MAX_ESTEIRA_PADRAO  = 15;
    localparam int TIMER_W_PADRAO        = 4;

    typedef enum logic [ESTADO_W-1:0] {
        IDLE         = 3'd0,
        ESTEIRA      = 3'd1,
        ENCHE        = 3'd2,
        ESPERA_ROLHA = 3'd3,
        VEDA         = 3'd4,
        CONTA        = 3'd5,
        FALHA        = 3'd6
    } estado_e;

endpackage

// File: rtl/controle_linha_engarrafamento_sincronizador_borda.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector that yields a one-clk pulse per low-to-high transition.
module sincronizador_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic borda_o
);

    logic meta_q;
    logic sinc_q;
    logic ant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sinc_q <= 1'b0;
            ant_q  <= 1'b0;
        end else begin
            meta_q <= d_i;
            sinc_q <= meta_q;
            ant_q  <= sinc_q;
        end
    end

    assign borda_o = sinc_q & ~ant_q;

endmodule

// File: rtl/controle_linha_engarrafamento.sv
// Sequencer for one bottle at a time: conveyor, fill valve and corker, with
// cork/bottle pulses for the counter stage and a fault/out-of-corks alarm.
module controle_linha_engarrafamento
    import controle_linha_engarrafamento_pkg::*;
#(
    parameter int T_ENCHE       = T_ENCHE_PADRAO,
    parameter int T_VEDA        = T_VEDA_PADRAO,
    parameter int T_MAX_ESTEIRA = T_MAX_ESTEIRA_PADRAO,
    parameter int TIMER_W       = TIMER_W_PADRAO
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                start,
    input  logic                sensor_garrafa,
    input  logic                rolha_disp,
    output logic                motor,
    output logic                valvula,
    output logic                vedador,
    output logic                pulso_rolha,
    output logic                pulso_garrafa,
    output logic                alarme,
    output logic [ESTADO_W-1:0] estado
);

    if (TIMER_W < 1 || TIMER_W > 16 ||
        T_ENCHE < 1 || T_ENCHE > (2**TIMER_W) - 1 ||
        T_VEDA < 1 || T_VEDA > (2**TIMER_W) - 1 ||
        T_MAX_ESTEIRA < 1 || T_MAX_ESTEIRA > (2**TIMER_W) - 1) begin : g_param_invalido
        $error("controle_linha_engarrafamento: timing constant does not fit in TIMER_W bits");
    end

    localparam logic [TIMER_W-1:0] LIM_ENCHE   = TIMER_W'(T_ENCHE);
    localparam logic [TIMER_W-1:0] LIM_VEDA    = TIMER_W'(T_VEDA);
    localparam logic [TIMER_W-1:0] LIM_ESTEIRA = TIMER_W'(T_MAX_ESTEIRA);

    estado_e            state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
    logic               start_meta_q, start_sinc_q;
    logic               sensor_borda;
    logic               motor_q, motor_d;
    logic               valvula_q, valvula_d;
    logic               vedador_q, vedador_d;
    logic               pulso_rolha_q, pulso_rolha_d;
    logic               pulso_garrafa_q, pulso_garrafa_d;
    logic               alarme_q, alarme_d;
    logic               expira_enche, expira_veda, expira_esteira;

    // start only needs a level, so it gets a plain two-flop path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_meta_q <= 1'b0;
            start_sinc_q <= 1'b0;
        end else begin
            start_meta_q <= start;
            start_sinc_q <= start_meta_q;
        end
    end

    sincronizador_borda u_sinc_sensor (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (sensor_garrafa),
        .borda_o (sensor_borda)
    );

    // A limit expires on the tick that brings the timer up to it, so a state
    // with limit N occupies exactly N tick periods.
    assign timer_inc      = (tick && (timer_q != '1)) ? timer_q + TIMER_W'(1) : timer_q;
    assign expira_enche   = tick && (timer_inc == LIM_ENCHE);
    assign expira_veda    = tick && (timer_inc == LIM_VEDA);
    assign expira_esteira = tick && (timer_inc == LIM_ESTEIRA);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_sinc_q) state_d = ESTEIRA;
            end
            ESTEIRA: begin
                if (sensor_borda)        state_d = ENCHE;
                else if (expira_esteira) state_d = FALHA;
                else if (!start_sinc_q)  state_d = IDLE;
            end
            ENCHE: begin
                if (expira_enche) state_d = rolha_disp ? VEDA : ESPERA_ROLHA;
            end
            ESPERA_ROLHA: begin
                if (rolha_disp) state_d = VEDA;
            end
            VEDA: begin
                if (expira_veda) state_d = CONTA;
            end
            CONTA: begin
                state_d = start_sinc_q ? ESTEIRA : IDLE;
            end
            FALHA: begin
                if (!start_sinc_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        timer_d = (state_d != state_q) ? '0 : timer_inc;

        // Outputs are decoded from the next state so the registered copies line up with state_q
        motor_d         = (state_d == ESTEIRA);
        valvula_d       = (state_d == ENCHE);
        vedador_d       = (state_d == VEDA);
        alarme_d        = (state_d == ESPERA_ROLHA) || (state_d == FALHA);
        pulso_rolha_d   = (state_d == VEDA) && (state_q != VEDA);
        pulso_garrafa_d = (state_d == CONTA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            motor_q         <= 1'b0;
            valvula_q       <= 1'b0;
            vedador_q       <= 1'b0;
            alarme_q        <= 1'b0;
            pulso_rolha_q   <= 1'b0;
            pulso_garrafa_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            motor_q         <= motor_d;
            valvula_q       <= valvula_d;
            vedador_q       <= vedador_d;
            alarme_q        <= alarme_d;
            pulso_rolha_q   <= pulso_rolha_d;
            pulso_garrafa_q <= pulso_garrafa_d;
        end
    end

    assign motor         = motor_q;
    assign valvula       = valvula_q;
    assign vedador       = vedador_q;
    assign alarme        = alarme_q;
    assign pulso_rolha   = pulso_rolha_q;
    assign pulso_garrafa = pulso_garrafa_q;
    assign estado        = state_q;

endmodule

// File: tb/tb_controle_linha_engarrafamento.sv
// Scoreboard bench: each scenario queues the state transitions and pulses it
// expects; a monitor turns DUT activity into events and matches them in order.
module tb_controle_linha_engarrafamento;

    localparam int EV_ESTADO  = 0;
    localparam int EV_ROLHA   = 1;
    localparam int EV_GARRAFA = 2;

    typedef struct {
        int kind;
        int value;
        int dur;
    } evento_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b1;
    logic       start = 1'b0;
    logic       sensor_garrafa = 1'b0;
    logic       rolha_disp = 1'b1;
    logic       motor, valvula, vedador, pulso_rolha, pulso_garrafa, alarme;
    logic [2:0] estado;

    evento_t expQ[$];
    int      checks = 0;
    int      fails = 0;
    bit      monitorOn = 1'b0;
    bit      tickSlow = 1'b0;

    controle_linha_engarrafamento dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .start          (start),
        .sensor_garrafa (sensor_garrafa),
        .rolha_disp     (rolha_disp),
        .motor          (motor),
        .valvula        (valvula),
        .vedador        (vedador),
        .pulso_rolha    (pulso_rolha),
        .pulso_garrafa  (pulso_garrafa),
        .alarme         (alarme),
        .estado         (estado)
    );

    always #5 clk = ~clk;

    // tick is either always high or high one clk in three
    initial begin
        int c = 0;
        forever begin
            @(negedge clk);
            c = (c + 1) % 3;
            tick = tickSlow ? (c == 0) : 1'b1;
        end
    end

    function automatic string kindName(input int k);
        case (k)
            EV_ESTADO:  return "estado";
            EV_ROLHA:   return "pulso_rolha";
            default:    return "pulso_garrafa";
        endcase
    endfunction

    task automatic pushExp(input int kind, input int value, input int dur);
        evento_t e;
        e.kind  = kind;
        e.value = value;
        e.dur   = dur;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic compareEvent(input int kind, input int value, input int dur);
        evento_t e;
        checks++;
        if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected event at %0t: got %s value=%0d n=%0d, required no event",
                     $time, kindName(kind), value, dur);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.value != value || (e.dur >= 0 && e.dur != dur)) begin
                fails++;
                $display("[TB] FAIL event at %0t: got %s value=%0d n=%0d, required %s value=%0d n=%0d",
                         $time, kindName(kind), value, dur, kindName(e.kind), e.value, e.dur);
            end
        end
    endtask

    // Monitor: a state change reports how many clks the previous state lasted;
    // a pulse reports the state it occurred in and the clk index within it.
    initial begin
        int lastState = 0;
        int cnt = 0;
        int e;
        logic [3:0] expAct;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                e = int'(estado);
                if (e != lastState) begin
                    compareEvent(EV_ESTADO, e, cnt);
                    lastState = e;
                    cnt = 1;
                end else begin
                    cnt++;
                end
                if (pulso_rolha)   compareEvent(EV_ROLHA, e, cnt - 1);
                if (pulso_garrafa) compareEvent(EV_GARRAFA, e, cnt - 1);
                expAct = {e == 1, e == 2, e == 4, (e == 3) || (e == 6)};
                checkOutput("actuators/alarme {motor,valvula,vedador,alarme}",
                            int'({motor, valvula, vedador, alarme}), int'(expAct));
            end
        end
    end

    task automatic waitState(input int code, input int bound, input string tag);
        int n = 0;
        while (int'(estado) != code && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (int'(estado) != code) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s timeout: estado got %0d, required %0d", tag, estado, code);
        end
    endtask

    task automatic waitDrain(input int bound, input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s drain: got %0d events outstanding, required 0", tag, expQ.size());
            expQ.delete();
        end
    endtask

    // Raise the bottle sensor k clks after the current point, hold for 3 clks
    task automatic applyStimulus(input int k);
        repeat (k) @(negedge clk);
        sensor_garrafa = 1'b1;
        repeat (3) @(negedge clk);
        sensor_garrafa = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required termination");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        int ticks;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        monitorOn = 1'b1;

        $display("[TB] reset/idle");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            checkOutput("reset/idle outputs", int'({estado, motor, valvula, vedador,
                        pulso_rolha, pulso_garrafa, alarme}), 0);
        end

        $display("[TB] normal cycle");
        pushExp(EV_ESTADO, 1, -1);
        pushExp(EV_ESTADO, 2, 8);
        pushExp(EV_ESTADO, 4, 8);
        pushExp(EV_ROLHA, 4, 0);
        pushExp(EV_ESTADO, 5, 4);
        pushExp(EV_GARRAFA, 5, 0);
        pushExp(EV_ESTADO, 1, 1);
        start = 1'b1;
        waitState(1, 20, "enter ESTEIRA");
        applyStimulus(5);
        waitDrain(100, "normal cycle");

        $display("[TB] no corks");
        pushExp(EV_ESTADO, 2, 5);
        pushExp(EV_ESTADO, 3, 8);
        pushExp(EV_ESTADO, 4, 21);
        pushExp(EV_ROLHA, 4, 0);
        pushExp(EV_ESTADO, 5, 4);
        pushExp(EV_GARRAFA, 5, 0);
        pushExp(EV_ESTADO, 1, 1);
        waitState(1, 20, "ESTEIRA before no-corks");
        rolha_disp = 1'b0;
        applyStimulus(2);
        waitState(3, 40, "enter ESPERA_ROLHA");
        repeat (20) @(negedge clk);
        rolha_disp = 1'b1;
        waitDrain(100, "no corks");

        $display("[TB] abort during ENCHE");
        pushExp(EV_ESTADO, 2, 5);
        pushExp(EV_ESTADO, 4, 8);
        pushExp(EV_ROLHA, 4, 0);
        pushExp(EV_ESTADO, 5, 4);
        pushExp(EV_GARRAFA, 5, 0);
        pushExp(EV_ESTADO, 0, 1);
        waitState(1, 20, "ESTEIRA before abort");
        applyStimulus(2);
        waitState(2, 20, "enter ENCHE");
        start = 1'b0;
        waitDrain(100, "abort");

        $display("[TB] timeout, fault hold, toggle and edge-vs-timeout priority");
        pushExp(EV_ESTADO, 1, -1);
        pushExp(EV_ESTADO, 6, 15);
        pushExp(EV_ESTADO, 0, 33);
        pushExp(EV_ESTADO, 1, 1);
        pushExp(EV_ESTADO, 2, 15);
        pushExp(EV_ESTADO, 4, 8);
        pushExp(EV_ROLHA, 4, 0);
        pushExp(EV_ESTADO, 5, 4);
        pushExp(EV_GARRAFA, 5, 0);
        pushExp(EV_ESTADO, 1, 1);
        start = 1'b1;
        waitState(1, 20, "enter ESTEIRA for timeout");
        waitState(6, 40, "enter FALHA");
        repeat (30) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        waitState(1, 20, "restart after FALHA");
        applyStimulus(12);
        waitDrain(100, "timeout/priority");

        $display("[TB] slow tick and reset mid-VEDA");
        tickSlow = 1'b1;
        pushExp(EV_ESTADO, 2, 8);
        pushExp(EV_ESTADO, 4, -1);
        pushExp(EV_ROLHA, 4, 0);
        pushExp(EV_ESTADO, 0, -1);
        waitState(1, 20, "ESTEIRA before slow tick");
        applyStimulus(5);
        waitState(2, 20, "enter ENCHE slow tick");
        cycles = 0;
        ticks = 0;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (int'(estado) != 2) break;
            cycles++;
            if (tick) ticks++;
            @(negedge clk);
        end
        checkOutput("ticks consumed in ENCHE", ticks, 8);
        checkOutput("ENCHE length within 22..24 clks", int'(cycles >= 22 && cycles <= 24), 1);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("async reset mid-VEDA outputs", int'({estado, motor, valvula, vedador,
                    pulso_rolha, pulso_garrafa, alarme}), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        waitDrain(20, "reset mid-VEDA");
        repeat (30) @(negedge clk);
        checkOutput("outstanding expectations at end", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
